// File: rtl/fixed_to_bcd.sv
// Converts a Q18.14 two's-complement value into sign + BCD digits for the display driver.
// Integer part via 18-step double-dabble, fraction via repeated multiply-by-10 with truncation.
module fixed_to_bcd #(
    parameter int FRAC_DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [31:0]       value,
    input  logic                     err_in,
    output logic                     busy,
    output logic                     done,
    output logic                     sign,
    output logic [23:0]              int_bcd,
    output logic [4*FRAC_DIGITS-1:0] frac_bcd,
    output logic                     error
);

    localparam int FW = 4 * FRAC_DIGITS;

    typedef enum logic [1:0] {IDLE, INT, FRAC, FIN} state_t;

    state_t         state;
    logic [4:0]     cnt;
    logic           err_q;
    logic           sign_q;
    logic [17:0]    int_sh;
    logic [13:0]    frac_q;
    logic [23:0]    bcd_acc;
    logic [FW-1:0]  frac_acc;
    logic [31:0]    mag;
    logic [17:0]    prod;
    logic           accept;

    function automatic logic [23:0] dabble_adjust(input logic [23:0] b);
        logic [23:0] r;
        r = b;
        for (int i = 0; i < 6; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [17:0] times_ten(input logic [13:0] f);
        logic [17:0] fe;
        fe = {4'b0000, f};
        return (fe << 3) + (fe << 1);
    endfunction

    // The cycle in which done is high is still IDLE, but a start there must be dropped.
    assign accept = (state == IDLE) && start && !done;
    assign mag    = value[31] ? $unsigned(-value) : $unsigned(value);
    assign prod   = times_ten(frac_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            err_q    <= 1'b0;
            sign_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sign     <= 1'b0;
            error    <= 1'b0;
            int_bcd  <= '0;
            frac_bcd <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        err_q  <= err_in;
                        sign_q <= err_in ? 1'b0 : value[31];
                        busy   <= 1'b1;
                        cnt    <= '0;
                        state  <= err_in ? FIN : INT;
                    end
                end
                INT: begin
                    if (cnt == 5'd17) begin
                        cnt   <= '0;
                        state <= FRAC;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                FRAC: begin
                    if (cnt == 5'(FRAC_DIGITS - 1)) begin
                        cnt   <= '0;
                        state <= FIN;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                FIN: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    error    <= err_q;
                    sign     <= sign_q;
                    int_bcd  <= err_q ? '0 : bcd_acc;
                    frac_bcd <= err_q ? '0 : frac_acc;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers: loaded on accept, no reset needed since FIN masks or overwrites them.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    int_sh   <= mag[31:14];
                    frac_q   <= mag[13:0];
                    bcd_acc  <= '0;
                    frac_acc <= '0;
                end
            end
            INT: begin
                {bcd_acc, int_sh} <= {dabble_adjust(bcd_acc), int_sh} << 1;
            end
            FRAC: begin
                frac_acc <= (frac_acc << 4) | FW'(prod[17:14]);
                frac_q   <= prod[13:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fixed_to_bcd.sv
// Scoreboard bench for fixed_to_bcd: directed vectors push expected results, a monitor checks each done.
module tb_fixed_to_bcd;

    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   value;
    logic          err_in;
    logic          busy;
    logic          done;
    logic          sign;
    logic [23:0]   int_bcd;
    logic [4*FD-1:0] frac_bcd;
    logic          error;

    int unsigned   cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;

    typedef struct {
        logic        s;
        logic [23:0] ib;
        logic [15:0] fb;
        logic        e;
        int unsigned at;
    } exp_t;

    exp_t sb[$];

    fixed_to_bcd #(.FRAC_DIGITS(FD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .value    (value),
        .err_in   (err_in),
        .busy     (busy),
        .done     (done),
        .sign     (sign),
        .int_bcd  (int_bcd),
        .frac_bcd (frac_bcd),
        .error    (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t x;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                x = sb.pop_front();
                chk("sign",     32'(sign),     32'(x.s));
                chk("int_bcd",  32'(int_bcd),  32'(x.ib));
                chk("frac_bcd", 32'(frac_bcd), 32'(x.fb));
                chk("error",    32'(error),    32'(x.e));
                chk("done_cycle", cyc,         x.at);
            end
        end
    end

    // Issue one request, then wait (bounded) for done while measuring busy length.
    task automatic convert(input logic [31:0] v, input logic e,
                           input logic s_exp, input logic [23:0] ib, input logic [15:0] fb);
        int  lat;
        int  nbusy;
        bit  seen;
        exp_t x;
        lat = e ? 1 : 19 + FD;
        @(negedge clk);
        start  = 1'b1;
        value  = v;
        err_in = e;
        x.s = s_exp; x.ib = ib; x.fb = fb; x.e = e; x.at = cyc + 1 + lat;
        sb.push_back(x);
        @(posedge clk);
        #1 start = 1'b0;
        err_in = 1'b0;
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) nbusy++;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got no done within 100 cycles for value 0x%08h, expected done", v);
        end else begin
            chk("busy_len", 32'(nbusy), 32'(lat));
        end
    endtask

    initial begin
        bit seen;
        rst_n  = 1'b0;
        start  = 1'b0;
        value  = '0;
        err_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {4'b0, busy, done, sign, error, int_bcd}, 32'h0);
        chk("reset_frac", 32'(frac_bcd), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(32'h0000_6000, 1'b0, 1'b0, 24'h000001, 16'h5000);
        convert(32'hFFFF_7000, 1'b0, 1'b1, 24'h000002, 16'h2500);
        convert(32'h8000_0000, 1'b0, 1'b1, 24'h131072, 16'h0000);
        convert(32'h7FFF_FFFF, 1'b0, 1'b0, 24'h131071, 16'h9999);
        convert(32'h1234_5678, 1'b1, 1'b0, 24'h000000, 16'h0000);
        convert(32'h0000_0666, 1'b0, 1'b0, 24'h000000, 16'h0999);
        convert(32'hFFFF_7000, 1'b1, 1'b0, 24'h000000, 16'h0000);
        convert(32'h0000_0001, 1'b0, 1'b0, 24'h000000, 16'h0000);
        convert(32'h0000_0000, 1'b0, 1'b0, 24'h000000, 16'h0000);

        // Second start mid-conversion must be ignored.
        begin
            exp_t x;
            @(negedge clk);
            start = 1'b1;
            value = 32'h0000_6000;
            x.s = 1'b0; x.ib = 24'h000001; x.fb = 16'h5000; x.e = 1'b0; x.at = cyc + 1 + 19 + FD;
            sb.push_back(x);
            @(posedge clk);
            #1 start = 1'b0;
            repeat (5) @(negedge clk);
            start = 1'b1;
            value = 32'h8000_0000;
            @(posedge clk);
            #1 start = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 60 && !seen; i++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            chk("ignored_start_done_seen", 32'(seen), 32'h1);
        end

        // Start in the done cycle must be ignored.
        start = 1'b1;
        value = 32'h7FFF_FFFF;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("start_on_done_busy", 32'(busy), 32'h0);
        repeat (30) @(negedge clk);
        chk("held_int_bcd", 32'(int_bcd), 32'h000001);

        // Reset mid-conversion aborts without done and clears outputs.
        @(negedge clk);
        start = 1'b1;
        value = 32'hFFFF_7000;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_ctrl", {28'b0, busy, done, sign, error}, 32'h0);
        chk("reset_mid_int", 32'(int_bcd), 32'h0);
        chk("reset_mid_frac", 32'(frac_bcd), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fixed_to_bcd.md
Name: fixed_to_bcd

Overview:
Sequential formatter that consumes a Q18.14 result from the fixed-point ALU (quotient, product, etc.) and produces a sign flag plus BCD digits for the display driver. It sits directly downstream of the divider and accepts its div_by_zero flag as an error input. The integer part is converted with an 18-step double-dabble. The fraction is converted by repeated multiply-by-10, with truncation.

Parameters:
FRAC_DIGITS, 4, number of fractional decimal digits produced (legal range 1..8).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a conversion; sampled only in IDLE
value  input  32  Q18.14 two's-complement operand; sampled with start
err_in  input  1  upstream error (divider div_by_zero); sampled with start
busy  output  1  high from the edge after start is accepted until the edge that asserts done
done  output  1  one-cycle pulse when outputs are valid
sign  output  1  1 when the sampled value is negative
int_bcd  output  24  6 BCD digits of the integer magnitude; [23:20] is the most significant digit
frac_bcd  output  4*FRAC_DIGITS  fractional BCD digits; the MS nibble is the first digit after the point
error  output  1  registered copy of err_in for the completed request

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, sign and error go to 0.
  - int_bcd and frac_bcd go to 0.
  - Reset mid-conversion aborts the conversion; no done is issued.
- States: IDLE, INT, FRAC, FIN.
- IDLE:
  - On a rising edge with start=1, capture err_in.
  - If err_in=1, go to FIN.
  - Otherwise capture the magnitude: mag = value[31] ? -value : value, computed as a 32-bit unsigned value. 0x80000000 gives mag=2^31, which is correct unsigned.
  - Capture sign = value[31], load the shift register with mag[31:14], load the fraction register with mag[13:0], clear the digit accumulators, set busy=1, go to INT.
- INT: 18 cycles of double-dabble.
  - Each cycle, add 3 to every BCD nibble that is >=5, then shift left one bit, taking in the next integer bit MSB-first.
  - A 5-bit counter tracks the cycles; after the 18th cycle go to FRAC.
  - Max integer magnitude is 131072, which fits 6 digits; no overflow is possible.
- FRAC: FRAC_DIGITS cycles.
  - Each cycle, p = frac*10 (18 bits).
  - The digit is p[17:14]; it is shifted into the frac accumulator from the LS side.
  - The new frac is p[13:0].
  - After the last digit, go to FIN.
- FIN (one cycle):
  - Drive int_bcd, frac_bcd, sign and error from the accumulators, pulse done=1, drop busy, return to IDLE.
  - On error, all digits and sign are 0 and error=1.
- Latency, counting the start-sampling edge as E0:
  - Normal conversion: done=1 after edge E0+19+FRAC_DIGITS (23 for the default), low after the next edge.
  - Error case: done=1 after edge E0+1.
- start while busy is ignored (no queueing).
- start in the same cycle done is high is ignored. start is accepted only from the cycle after FIN, i.e. back in IDLE.
- Outputs hold their values until the next FIN or reset.
- Fraction digits are truncated, never rounded.

Test Plan:
- value=0x00006000 (1.5), start pulse -> done after 23 cycles; sign=0, int_bcd=0x000001, frac_bcd=0x5000, error=0; busy high for exactly 23 cycles.
- value=0xFFFF7000 (-2.25) -> sign=1, int_bcd=0x000002, frac_bcd=0x2500.
- Boundary magnitudes:
  - value=0x80000000 -> sign=1, int_bcd=0x131072, frac_bcd=0x0000.
  - value=0x7FFFFFFF -> sign=0, int_bcd=0x131071, frac_bcd=0x9999.
- Truncation:
  - value=0x00000666 -> int_bcd=0x000000, frac_bcd=0x0999.
  - value=0x00000001 -> frac_bcd=0x0000.
  - value=0 -> sign=0, all digits 0.
- err_in=1 with value=0x12345678 -> done two edges after start (one cycle in FIN); error=1, sign=0, digits all 0.
- Control boundaries:
  - Second start pulse at cycle 5 of a conversion -> ignored; only one done, with the first value's result.
  - rst_n low at cycle 10 -> busy=0 and outputs 0 immediately; no done until a new start.
